// File: rtl/bypass_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : bypass_hazard_unit
//  Purpose  : ID-stage operand bypass select and decode-stall generation.
//             For each source operand it picks the register file or the
//             youngest matching in-flight producer. It stalls decode on
//             load-use, long-op busy registers, long-op WAW and long-unit
//             occupancy. It also owns the long-op busy scoreboard, the
//             outstanding long-op counter and a saturating stall counter.
//  Ports    : clk_i/rst_i        clock, synchronous active-high reset
//             id_*_i             decoding instruction (sources, dest, kind)
//             stg_*_i            per bypass stage producer info (0 = EX)
//             lo_done_i/lo_rd_*  long-latency unit completion
//             sel_o              per operand: 0 = RF, s+1 = stage s
//             stall_o            hold ID, insert bubble
//             lo_busy_o          scoreboard bits (debug)
//             stall_cnt_o        saturating stall-cycle count
//  Revision : 1.0 - initial release
// ============================================================================
module bypass_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LONG   = 2,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             id_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    id_rs_addr_i,
  input  logic [NUM_SRC-1:0]               id_rs_used_i,
  input  logic [REG_ADDR_W-1:0]            id_rd_addr_i,
  input  logic                             id_we_i,
  input  logic                             id_long_i,
  input  logic [NUM_STAGES-1:0]            stg_valid_i,
  input  logic [NUM_STAGES-1:0]            stg_we_i,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] stg_rd_addr_i,
  input  logic [NUM_STAGES-1:0]            stg_data_rdy_i,
  input  logic                             lo_done_i,
  input  logic [REG_ADDR_W-1:0]            lo_rd_addr_i,
  output logic [NUM_SRC*SEL_W-1:0]         sel_o,
  output logic                             stall_o,
  output logic [2**REG_ADDR_W-1:0]         lo_busy_o,
  output logic [31:0]                      stall_cnt_o
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int CNT_W    = $clog2(MAX_LONG + 1);
  localparam logic [CNT_W-1:0] MAX_LONG_C = CNT_W'(MAX_LONG);

  logic [NUM_REGS-1:0]      busy;
  logic [NUM_REGS-1:0]      busy_nxt;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         outstanding_nxt;
  logic [31:0]              stall_cnt;

  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic [NUM_SRC-1:0]       data_haz_v;
  logic [NUM_SRC-1:0]       busy_haz_v;
  logic                     waw_haz;
  logic                     occ_haz;
  logic                     stall;
  logic                     issue;
  logic                     done_eff;

  // --------------------------------------------------------------------------
  // Per-operand producer search
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic [NUM_STAGES-1:0] match;
    logic [SEL_W-1:0]      sel;
    logic                  data_haz;

    assign rs = id_rs_addr_i[k*REG_ADDR_W +: REG_ADDR_W];

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stg
      assign match[s] = stg_valid_i[s] & stg_we_i[s] &
                        (stg_rd_addr_i[s*REG_ADDR_W +: REG_ADDR_W] == rs) &
                        (rs != '0) & id_rs_used_i[k];
    end

    // Walk from oldest to youngest so the youngest match overwrites; the
    // readiness of the winning stage alone decides the load-use hazard.
    always_comb begin
      sel      = '0;
      data_haz = 1'b0;
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
        if (match[s]) begin
          sel      = SEL_W'(s + 1);
          data_haz = ~stg_data_rdy_i[s];
        end
      end
    end

    assign sel_raw[k*SEL_W +: SEL_W] = sel;
    assign data_haz_v[k] = data_haz;
    assign busy_haz_v[k] = id_rs_used_i[k] & (rs != '0) & busy[rs];
  end

  // --------------------------------------------------------------------------
  // Long-unit hazards and stall
  // --------------------------------------------------------------------------
  assign waw_haz = id_long_i & id_we_i & (id_rd_addr_i != '0) & busy[id_rd_addr_i];
  // A completion this cycle frees a slot, so a full unit still accepts.
  assign occ_haz = id_long_i & (outstanding == MAX_LONG_C) & ~lo_done_i;

  assign stall = ~rst_i & id_valid_i &
                 ((|data_haz_v) | (|busy_haz_v) | waw_haz | occ_haz);

  assign issue    = id_valid_i & id_long_i & ~stall;
  // Completions with nothing outstanding (e.g. after a reset) are dropped.
  assign done_eff = lo_done_i & (outstanding != '0);

  // --------------------------------------------------------------------------
  // Scoreboard and counter next state
  // --------------------------------------------------------------------------
  always_comb begin
    busy_nxt = busy;
    if (lo_done_i) begin
      busy_nxt[lo_rd_addr_i] = 1'b0;
    end
    // Set after clear: a same-cycle issue to the completing register wins.
    if (issue && id_we_i && (id_rd_addr_i != '0)) begin
      busy_nxt[id_rd_addr_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    outstanding_nxt = outstanding;
    case ({issue, done_eff})
      2'b10:   outstanding_nxt = outstanding + CNT_W'(1);
      2'b01:   outstanding_nxt = outstanding - CNT_W'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy        <= '0;
      outstanding <= '0;
      stall_cnt   <= '0;
    end else begin
      busy        <= busy_nxt;
      outstanding <= outstanding_nxt;
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sel_o       = rst_i ? '0 : sel_raw;
  assign stall_o     = stall;
  assign lo_busy_o   = busy;
  assign stall_cnt_o = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bypass_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bypass_hazard_unit
//  Purpose  : Self-checking bench for bypass_hazard_unit. Expected values are
//             queued as each cycle's stimulus is applied and compared once
//             the combinational outputs have settled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bypass_hazard_unit;

  localparam int NUM_SRC    = 2;
  localparam int NUM_STAGES = 3;
  localparam int REG_ADDR_W = 5;
  localparam int MAX_LONG   = 2;
  localparam int SEL_W      = 2;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0]    id_rs_addr;
  logic [NUM_SRC-1:0]               id_rs_used;
  logic [REG_ADDR_W-1:0]            id_rd_addr;
  logic                             id_we;
  logic                             id_long;
  logic [NUM_STAGES-1:0]            stg_valid;
  logic [NUM_STAGES-1:0]            stg_we;
  logic [NUM_STAGES*REG_ADDR_W-1:0] stg_rd_addr;
  logic [NUM_STAGES-1:0]            stg_data_rdy;
  logic                             lo_done;
  logic [REG_ADDR_W-1:0]            lo_rd_addr;
  logic [NUM_SRC*SEL_W-1:0]         sel;
  logic                             stall;
  logic [2**REG_ADDR_W-1:0]         lo_busy;
  logic [31:0]                      stall_cnt;

  bypass_hazard_unit #(
    .NUM_SRC    (NUM_SRC),
    .NUM_STAGES (NUM_STAGES),
    .REG_ADDR_W (REG_ADDR_W),
    .MAX_LONG   (MAX_LONG),
    .SEL_W      (SEL_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_valid_i     (id_valid),
    .id_rs_addr_i   (id_rs_addr),
    .id_rs_used_i   (id_rs_used),
    .id_rd_addr_i   (id_rd_addr),
    .id_we_i        (id_we),
    .id_long_i      (id_long),
    .stg_valid_i    (stg_valid),
    .stg_we_i       (stg_we),
    .stg_rd_addr_i  (stg_rd_addr),
    .stg_data_rdy_i (stg_data_rdy),
    .lo_done_i      (lo_done),
    .lo_rd_addr_i   (lo_rd_addr),
    .sel_o          (sel),
    .stall_o        (stall),
    .lo_busy_o      (lo_busy),
    .stall_cnt_o    (stall_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 = sel vector, 1 = stall, 2 = busy bit idx, 3 = stall count
  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks   = 0;
  int          n_pass     = 0;
  logic [31:0] exp_cnt    = 32'd0;
  logic        pend_stall = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_rs_addr   = '0;
    id_rs_used   = '0;
    id_rd_addr   = '0;
    id_we        = 1'b0;
    id_long      = 1'b0;
    stg_valid    = '0;
    stg_we       = '0;
    stg_rd_addr  = '0;
    stg_data_rdy = '0;
    lo_done      = 1'b0;
    lo_rd_addr   = '0;
  endtask

  task automatic set_stage(input int s, input logic [REG_ADDR_W-1:0] rd,
                           input logic rdy);
    stg_valid[s]    = 1'b1;
    stg_we[s]       = 1'b1;
    stg_rd_addr[s*REG_ADDR_W +: REG_ADDR_W] = rd;
    stg_data_rdy[s] = rdy;
  endtask

  task automatic set_rs(input int k, input logic [REG_ADDR_W-1:0] rs);
    id_valid      = 1'b1;
    id_rs_used[k] = 1'b1;
    id_rs_addr[k*REG_ADDR_W +: REG_ADDR_W] = rs;
  endtask

  task automatic set_long(input logic [REG_ADDR_W-1:0] rd);
    id_valid   = 1'b1;
    id_long    = 1'b1;
    id_we      = 1'b1;
    id_rd_addr = rd;
  endtask

  task automatic set_done(input logic [REG_ADDR_W-1:0] rd);
    lo_done    = 1'b1;
    lo_rd_addr = rd;
  endtask

  // sel is only meaningful when not stalling
  task automatic expect_out(input string tag, input logic [3:0] s,
                            input logic st);
    if (!st) sb.push_back('{{tag, "_sel"}, 0, 0, {28'd0, s}});
    sb.push_back('{{tag, "_stall"}, 1, 0, {31'd0, st}});
    sb.push_back('{{tag, "_cnt"}, 3, 0, exp_cnt});
    pend_stall = st;
  endtask

  task automatic expect_busy(input string tag, input int idx, input logic v);
    sb.push_back('{tag, 2, idx, {31'd0, v}});
  endtask

  // Compare queued expectations mid-cycle, then advance one clock.
  task automatic tick();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       check_val(e.tag, 32'(sel), e.val);
        1:       check_val(e.tag, {31'd0, stall}, e.val);
        2:       check_val(e.tag, {31'd0, lo_busy[e.idx]}, e.val);
        default: check_val(e.tag, stall_cnt, e.val);
      endcase
    end
    @(posedge clk);
    if (rst) exp_cnt = 32'd0;
    else if (pend_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    pend_stall = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);

    // Reset holds outputs low even with a hazard present
    set_rs(0, 5'd9); set_stage(0, 5'd9, 1'b0);
    expect_out("rst_state", 4'b0000, 1'b0);
    tick();
    rst = 1'b0;

    // EX and MEM both produce r5: youngest (EX) wins
    idle(); set_rs(0, 5'd5); set_stage(0, 5'd5, 1'b1); set_stage(1, 5'd5, 1'b1);
    expect_out("byp_ex", 4'b0001, 1'b0);
    tick();

    // Youngest not ready: older ready copy must not be used
    idle(); set_rs(0, 5'd5); set_stage(0, 5'd5, 1'b0); set_stage(1, 5'd5, 1'b1);
    expect_out("old_rdy_ignored", 4'b0000, 1'b1);
    tick();

    // Load-use on operand 1, then bypass from MEM
    idle(); set_rs(1, 5'd7); set_stage(0, 5'd7, 1'b0);
    expect_out("lu_stall", 4'b0000, 1'b1);
    tick();
    idle(); set_rs(1, 5'd7); set_stage(1, 5'd7, 1'b1);
    expect_out("lu_mem", 4'b1000, 1'b0);
    tick();

    // Long op r9, readers stall through the done cycle
    idle(); set_long(5'd9);
    expect_out("lo_issue9", 4'b0000, 1'b0);
    expect_busy("busy9_pre", 9, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); set_rs(0, 5'd9);
      expect_out("busy_rd9", 4'b0000, 1'b1);
      expect_busy("busy9_set", 9, 1'b1);
      tick();
    end
    idle(); set_rs(0, 5'd9); set_done(5'd9); set_stage(2, 5'd9, 1'b1);
    expect_out("done9_stall", 4'b0000, 1'b1);
    expect_busy("busy9_done", 9, 1'b1);
    tick();
    idle(); set_rs(0, 5'd9);
    expect_out("after9", 4'b0000, 1'b0);
    expect_busy("busy9_clr", 9, 1'b0);
    tick();

    // Occupancy with MAX_LONG = 2
    idle(); set_long(5'd3);
    expect_out("issue3", 4'b0000, 1'b0);
    tick();
    idle(); set_long(5'd4);
    expect_out("issue4", 4'b0000, 1'b0);
    tick();
    idle(); set_long(5'd10);
    expect_out("occ_stall", 4'b0000, 1'b1);
    expect_busy("busy3", 3, 1'b1);
    expect_busy("busy4", 4, 1'b1);
    tick();
    idle(); set_long(5'd10); set_done(5'd3);
    expect_out("occ_done", 4'b0000, 1'b0);
    tick();
    idle(); set_long(5'd11);
    expect_out("occ_still", 4'b0000, 1'b1);
    expect_busy("busy3_clr", 3, 1'b0);
    expect_busy("busy10", 10, 1'b1);
    tick();

    // WAW on a busy destination while a slot is free
    idle(); set_done(5'd4);
    tick();
    idle(); set_long(5'd10);
    expect_out("waw", 4'b0000, 1'b1);
    expect_busy("busy4_clr", 4, 1'b0);
    tick();
    idle(); set_done(5'd10);
    tick();

    // Same-cycle issue and done on r6: set wins
    idle(); set_long(5'd13);
    expect_out("issue13", 4'b0000, 1'b0);
    expect_busy("busy10_clr", 10, 1'b0);
    tick();
    idle(); set_long(5'd6); set_done(5'd6);
    expect_out("same_cycle6", 4'b0000, 1'b0);
    tick();

    // Register 0 never bypasses or stalls
    idle(); set_rs(0, 5'd0); set_rs(1, 5'd0); set_stage(0, 5'd0, 1'b0);
    expect_out("zero_src", 4'b0000, 1'b0);
    expect_busy("busy6_kept", 6, 1'b1);
    tick();

    // Fill to two outstanding, then reset
    idle(); set_long(5'd14);
    expect_out("issue14", 4'b0000, 1'b0);
    tick();
    idle(); set_long(5'd15);
    expect_out("pre_rst_occ", 4'b0000, 1'b1);
    expect_busy("busy14", 14, 1'b1);
    tick();
    idle(); rst = 1'b1; set_long(5'd15); set_rs(0, 5'd5); set_stage(0, 5'd5, 1'b0);
    expect_out("mid_rst", 4'b0000, 1'b0);
    tick();
    rst = 1'b0;
    idle(); set_done(5'd6);
    expect_out("post_rst", 4'b0000, 1'b0);
    expect_busy("rst_busy6", 6, 1'b0);
    expect_busy("rst_busy13", 13, 1'b0);
    expect_busy("rst_busy14", 14, 1'b0);
    tick();

    // Stray done after reset must not underflow: exactly two slots free
    idle(); set_long(5'd1);
    expect_out("post_issue1", 4'b0000, 1'b0);
    tick();
    idle(); set_long(5'd2);
    expect_out("post_issue2", 4'b0000, 1'b0);
    tick();
    idle(); set_long(5'd3);
    expect_out("no_underflow", 4'b0000, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
